io_output_port: RTL and testbench

Processor-side output port for the stack processor: the inverse direction of the `getin`/`getin2` input path. On a processor write strobe it captures a word (normally `top_of_stack`) into a small FIFO. It then presents the buffered words, oldest first, to an external consumer over a valid/ready handshake. It sits between `final_processor` and off-chip or testbench sinks, so the processor never stalls on a slow consumer until the buffer is full.

---
 rtl/io_output_port.sv | 70 +++++++
 tb/tb_io_output_port.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_output_port.sv
// Processor output port: buffers write-strobed words in a DEPTH-entry FIFO and
// presents them oldest-first over valid/ready. Optional status: IO_OUTPUT_PORT_STATUS_EN.
module io_output_port #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    output logic                     full,
    output logic                     empty,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready
`ifdef IO_OUTPUT_PORT_STATUS_EN
    ,
    output logic                     overflow,
    input  logic                     clr_ovf,
    output logic [$clog2(DEPTH):0]   count
`endif
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      cnt;
    logic             do_rd, do_wr;

    assign empty     = (cnt == '0);
    assign full      = (cnt == (AW+1)'(DEPTH));
    assign out_valid = !empty;
    // Mask keeps unreset memory contents from ever reaching the consumer.
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    assign do_rd = out_valid && out_ready;
    assign do_wr = wr_en && (!full || do_rd);

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

`ifdef IO_OUTPUT_PORT_STATUS_EN
    logic drop;
    assign drop  = wr_en && full && !do_rd;
    assign count = cnt;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset)       overflow <= 1'b0;
        else if (clr_ovf) overflow <= 1'b0;
        else if (drop)    overflow <= 1'b1;
    end
`endif
endmodule

// File: tb/tb_io_output_port.sv
// Directed bench for io_output_port; status checks compile in with IO_OUTPUT_PORT_STATUS_EN.
module tb_io_output_port;
    logic        CLK = 1'b0;
    logic        reset = 1'b0;
    logic        wr_en = 1'b0;
    logic [15:0] wr_data = '0;
    logic        full, empty, out_valid;
    logic [15:0] out_data;
    logic        out_ready = 1'b0;
`ifdef IO_OUTPUT_PORT_STATUS_EN
    logic        overflow;
    logic        clr_ovf = 1'b0;
    logic [2:0]  count;
`endif

    int compared = 0;
    int mismatched = 0;

    io_output_port #(.WIDTH(16), .DEPTH(4)) dut (
        .CLK(CLK), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .empty(empty), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready)
`ifdef IO_OUTPUT_PORT_STATUS_EN
        , .overflow(overflow), .clr_ovf(clr_ovf), .count(count)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (5) tick();
        compared++;
        if ({empty, full, out_valid, out_data} !== {1'b1, 1'b0, 1'b0, 16'h0000}) begin
            mismatched++;
            $display("FAIL reset_hold: e/f/v/d=%b%b%b %h want 100 0000", empty, full, out_valid, out_data);
        end
        reset = 1'b1;
        tick();
        compared++;
        if ({empty, full, out_valid, out_data} !== {1'b1, 1'b0, 1'b0, 16'h0000}) begin
            mismatched++;
            $display("FAIL reset_release: e/f/v/d=%b%b%b %h want 100 0000", empty, full, out_valid, out_data);
        end
`ifdef IO_OUTPUT_PORT_STATUS_EN
        compared++;
        if ({overflow, count} !== 4'b0000) begin
            mismatched++;
            $display("FAIL reset_status: ovf=%b count=%0d want 0 0", overflow, count);
        end
`endif
    endtask

    task automatic test_basic();
        out_ready = 1'b0;
        wr_en = 1'b1; wr_data = 16'h0001;
        tick();
        compared++;
        if (out_valid !== 1'b1 || out_data !== 16'h0001) begin
            mismatched++;
            $display("FAIL basic_latency: v=%b d=%h want 1 0001", out_valid, out_data);
        end
        wr_data = 16'h0004;
        tick();
        wr_en = 1'b0;
`ifdef IO_OUTPUT_PORT_STATUS_EN
        compared++;
        if (count !== 3'd2) begin
            mismatched++;
            $display("FAIL basic_count: got %0d want 2", count);
        end
`endif
        tick();
        compared++;
        if (out_data !== 16'h0001) begin
            mismatched++;
            $display("FAIL basic_hold: got %h want 0001", out_data);
        end
        out_ready = 1'b1;
        tick();
        compared++;
        if (out_data !== 16'h0004) begin
            mismatched++;
            $display("FAIL basic_second: got %h want 0004", out_data);
        end
        tick();
        out_ready = 1'b0;
        compared++;
        if (empty !== 1'b1 || out_valid !== 1'b0 || out_data !== 16'h0000) begin
            mismatched++;
            $display("FAIL basic_empty: e=%b v=%b d=%h want 1 0 0000", empty, out_valid, out_data);
        end
    endtask

    task automatic fill_10_13();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wr_data = 16'h0010 + 16'(i);
            tick();
        end
        wr_en = 1'b0;
    endtask

    task automatic test_overflow();
        fill_10_13();
        compared++;
        if (full !== 1'b1) begin
            mismatched++;
            $display("FAIL ovf_full: got %b want 1", full);
        end
        wr_en = 1'b1; wr_data = 16'h00FF;
        tick();
        wr_en = 1'b0;
        compared++;
        if (full !== 1'b1) begin
            mismatched++;
            $display("FAIL ovf_full_after_drop: got %b want 1", full);
        end
`ifdef IO_OUTPUT_PORT_STATUS_EN
        compared++;
        if (overflow !== 1'b1) begin
            mismatched++;
            $display("FAIL ovf_flag: got %b want 1", overflow);
        end
`endif
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            compared++;
            if (out_data !== 16'h0010 + 16'(i)) begin
                mismatched++;
                $display("FAIL ovf_drain%0d: got %h want %h", i, out_data, 16'h0010 + 16'(i));
            end
            tick();
        end
        out_ready = 1'b0;
        compared++;
        if (empty !== 1'b1 || out_data !== 16'h0000) begin
            mismatched++;
            $display("FAIL ovf_drained_empty: e=%b d=%h want 1 0000", empty, out_data);
        end
`ifdef IO_OUTPUT_PORT_STATUS_EN
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        compared++;
        if (overflow !== 1'b0) begin
            mismatched++;
            $display("FAIL ovf_clear: got %b want 0", overflow);
        end
`endif
    endtask

    task automatic test_full_pass();
        logic [15:0] exp [4];
        exp[0] = 16'h0011; exp[1] = 16'h0012; exp[2] = 16'h0013; exp[3] = 16'h0020;
        fill_10_13();
        wr_en = 1'b1; wr_data = 16'h0020; out_ready = 1'b1;
        tick();
        wr_en = 1'b0; out_ready = 1'b0;
        compared++;
        if (full !== 1'b1) begin
            mismatched++;
            $display("FAIL pass_full: got %b want 1", full);
        end
`ifdef IO_OUTPUT_PORT_STATUS_EN
        compared++;
        if (overflow !== 1'b0) begin
            mismatched++;
            $display("FAIL pass_overflow: got %b want 0", overflow);
        end
`endif
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            compared++;
            if (out_data !== exp[i]) begin
                mismatched++;
                $display("FAIL pass_drain%0d: got %h want %h", i, out_data, exp[i]);
            end
            tick();
        end
        out_ready = 1'b0;
        compared++;
        if (empty !== 1'b1) begin
            mismatched++;
            $display("FAIL pass_empty: got %b want 1", empty);
        end
    endtask

    task automatic test_wrap();
        logic [15:0] q [$];
        int sent, got;
        logic rd, mfull;
        sent = 0; got = 0;
        for (int cyc = 0; cyc < 200 && got < 12; cyc++) begin
            wr_en     = (sent < 12);
            wr_data   = 16'h0100 + 16'(sent);
            out_ready = (sent < 12) ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            compared++;
            if (out_valid !== (q.size() != 0)) begin
                mismatched++;
                $display("FAIL wrap_valid c%0d: got %b want %b", cyc, out_valid, q.size() != 0);
            end
            mfull = (q.size() == 4);
            rd    = (q.size() != 0) && out_ready;
            if (rd) begin
                compared++;
                if (out_data !== q[0]) begin
                    mismatched++;
                    $display("FAIL wrap_data c%0d: got %h want %h", cyc, out_data, q[0]);
                end
                void'(q.pop_front());
                got++;
            end
            if (wr_en && (!mfull || rd)) begin
                q.push_back(wr_data);
                sent++;
            end
            tick();
        end
        wr_en = 1'b0; out_ready = 1'b0;
        compared++;
        if (got !== 12 || empty !== 1'b1) begin
            mismatched++;
            $display("FAIL wrap_total: read %0d empty=%b want 12 1", got, empty);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; wr_data = 16'h0030 + 16'(i);
            tick();
        end
        wr_en = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        compared++;
        if ({empty, out_valid, out_data} !== {1'b1, 1'b0, 16'h0000}) begin
            mismatched++;
            $display("FAIL rstmid_async: e/v/d=%b%b %h want 10 0000", empty, out_valid, out_data);
        end
        tick();
        #3;
        reset = 1'b1;
        out_ready = 1'b1;
        tick();
        compared++;
        if (out_valid !== 1'b0 || out_data !== 16'h0000) begin
            mismatched++;
            $display("FAIL rstmid_stale: v=%b d=%h want 0 0000", out_valid, out_data);
        end
        out_ready = 1'b0;
        wr_en = 1'b1; wr_data = 16'h0040;
        tick();
        wr_en = 1'b0;
        compared++;
        if (out_valid !== 1'b1 || out_data !== 16'h0040) begin
            mismatched++;
            $display("FAIL rstmid_fresh: v=%b d=%h want 1 0040", out_valid, out_data);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_full_pass();
        test_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
